// File: rtl/gray_to_rgb.sv
// Gray-to-RGB two-stage pipeline: S1 rescales y from n to m bits, S2 applies per-channel gain.
// Optional macro GRAY_TO_RGB_TINT_EN enables the programmable gains; otherwise r = g = b = scaled y.
module gray_to_rgb #(
  parameter int n = 8,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] y,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [m-1:0] r,
  output logic [m-1:0] g,
  output logic [m-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_sel,
  input  logic [7:0]   cfg_data
);

  // Output bit m-1-i takes input bit n-1-(i mod n): MSB-first replication when
  // widening, identity at equal width, MSB truncation when narrowing.
  function automatic logic [m-1:0] scale(input logic [n-1:0] v);
    logic [m-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < m; i++) begin
      s[m-1-i] = v[n-1-(i%n)];
    end
    return s;
  endfunction

  logic         s1_valid;
  logic         s2_valid;
  logic [m-1:0] s1_data;
  logic         s1_adv;
  logic         s2_adv;
  logic [m-1:0] r_next;
  logic [m-1:0] g_next;
  logic [m-1:0] b_next;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

`ifdef GRAY_TO_RGB_TINT_EN
  logic [7:0] gain_r;
  logic [7:0] gain_g;
  logic [7:0] gain_b;

  function automatic logic [m-1:0] apply_gain(input logic [m-1:0] ys, input logic [7:0] gain);
    logic [m+8:0] prod;
    prod = (m+9)'(ys) * (m+9)'({1'b0, gain} + 9'd1);
    return m'(prod >> 8);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain_r <= '1;
      gain_g <= '1;
      gain_b <= '1;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    gain_r <= cfg_data;
        2'd1:    gain_g <= cfg_data;
        2'd2:    gain_b <= cfg_data;
        default: ;
      endcase
    end
  end

  assign r_next = apply_gain(s1_data, gain_r);
  assign g_next = apply_gain(s1_data, gain_g);
  assign b_next = apply_gain(s1_data, gain_b);
`else
  logic cfg_unused;
  assign cfg_unused = ^{cfg_we, cfg_sel, cfg_data};

  assign r_next = s1_data;
  assign g_next = s1_data;
  assign b_next = s1_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1_data <= scale(y);
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          r <= r_next;
          g <= g_next;
          b <= b_next;
        end
      end
    end
  end

endmodule
